// File: rtl/mem_word_packer.sv
// Packs FIELD_W-bit fields MSB-first into a WORD_W-bit memory word and issues a
// single-cycle write strobe per committed word. The word can end early (zero padded) or be flushed.
module mem_word_packer #(
    parameter  int FIELD_W    = 7,
    parameter  int NUM_FIELDS = 5,
    parameter  int CNT_W      = 8,
    localparam int WORD_W     = FIELD_W * NUM_FIELDS
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FIELD_W-1:0] in_field,
    input  logic               in_last,
    input  logic               flush,
    output logic [WORD_W-1:0]  din,
    output logic               wren,
    output logic               short_pkt,
    output logic [CNT_W-1:0]   words_written
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam int                IDX_W    = $clog2(NUM_FIELDS) + 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_FIELDS - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]  pack_q, pack_d;
    logic [WORD_W-1:0]  din_q, din_d;
    logic               wren_q, wren_d;
    logic               short_q, short_d;
    logic [CNT_W-1:0]   words_q, words_d;

    logic               accept;
    logic               is_final;
    logic [WORD_W-1:0]  word_next;

    // Field k lands in slot k counted from the MSB end of the word.
    function automatic logic [WORD_W-1:0] place_field(input logic [FIELD_W-1:0] field,
                                                      input logic [IDX_W-1:0]   idx);
        logic [WORD_W-1:0] res;
        res = '0;
        for (int k = 0; k < NUM_FIELDS; k++) begin
            if (idx == IDX_W'(k)) begin
                res[WORD_W-1-k*FIELD_W -: FIELD_W] = field;
            end
        end
        return res;
    endfunction

    assign in_ready  = (state_q != WRITE) && !flush;
    assign accept    = in_valid && in_ready;
    assign is_final  = (idx_q == LAST_IDX) || in_last;
    assign word_next = pack_q | place_field(in_field, idx_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pack_d  = pack_q;
        din_d   = din_q;
        wren_d  = 1'b0;
        short_d = 1'b0;
        words_d = words_q;
        case (state_q)
            IDLE, FILL: begin
                if (flush) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    pack_d  = '0;
                end else if (accept) begin
                    if (is_final) begin
                        // din is loaded on the accepting edge so it is stable for the whole wren cycle.
                        state_d = WRITE;
                        din_d   = word_next;
                        wren_d  = 1'b1;
                        short_d = (idx_q != LAST_IDX);
                        idx_d   = '0;
                        pack_d  = '0;
                    end else begin
                        state_d = FILL;
                        pack_d  = word_next;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
                words_d = words_q + CNT_W'(1);
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                pack_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pack_q  <= '0;
            din_q   <= '0;
            wren_q  <= 1'b0;
            short_q <= 1'b0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pack_q  <= pack_d;
            din_q   <= din_d;
            wren_q  <= wren_d;
            short_q <= short_d;
            words_q <= words_d;
        end
    end

    assign din           = din_q;
    assign wren          = wren_q;
    assign short_pkt     = short_q;
    assign words_written = words_q;

endmodule

// File: doc/mem_word_packer.md
Name: mem_word_packer

Overview:
- Upstream feeder for the 35-bit MemoryUnit.
- Accepts a stream of 7-bit fields over a valid/ready handshake and packs them MSB-first into one 35-bit word.
- Presents the packed word on din and issues a single-cycle wren pulse, so the memory captures each completed word exactly once.
- Supports early termination with zero padding, discard of a partial word, and a running count of committed words.

Parameters:
- FIELD_W, 7, width of one input field.
- NUM_FIELDS, 5, number of fields per word; WORD_W = FIELD_W*NUM_FIELDS (35 by default).
- CNT_W, 8, width of the words_written counter.

Ports:
- clk  input  1  system clock, rising-edge.
- arst  input  1  asynchronous reset, active-high.
- in_valid  input  1  in_field is valid this cycle.
- in_ready  output  1  packer can accept a field this cycle.
- in_field  input  FIELD_W  field data.
- in_last  input  1  qualifies in_field as the final field of the current word.
- flush  input  1  synchronous discard of a partially filled word.
- din  output  WORD_W  packed word to MemoryUnit din; registered.
- wren  output  1  write strobe to MemoryUnit wren; one-cycle pulse.
- short_pkt  output  1  one-cycle flag, coincident with wren, when the word was zero-padded.
- words_written  output  CNT_W  number of committed words; wraps.

Behaviour:
- Single clock domain. arst is asynchronous and active-high.
- On arst: state=IDLE, field count=0, pack register=0, din=0, wren=0, short_pkt=0, words_written=0. in_ready=1 once the block is in IDLE.
- Reset mid-word discards the partial word. wren drops immediately, even mid-pulse.
- States:
  - IDLE: no fields held.
  - FILL: 1..NUM_FIELDS-1 fields held.
  - WRITE: commit cycle.
- in_ready = (state != WRITE) && !flush. This is combinational from state and flush.
- A field is accepted on a rising edge when in_valid && in_ready.
- The k-th accepted field (k = 0..NUM_FIELDS-1) goes to pack bits [WORD_W-1-k*FIELD_W -: FIELD_W], so field 0 occupies [34:28].
- Transitions:
  - IDLE -> FILL on accept when in_last=0 and NUM_FIELDS>1.
  - IDLE/FILL -> WRITE on accept of field NUM_FIELDS-1, or on any accept with in_last=1.
  - FILL -> IDLE on flush. Pack register and count are cleared; no write occurs.
  - WRITE -> IDLE unconditionally after one cycle.
- Commit edge: the same edge that accepts the final field loads din with the completed word. Unfilled field slots are 0.
- WRITE cycle:
  - wren=1 for exactly one cycle; in_ready=0.
  - short_pkt=1 if the word ended via in_last before field NUM_FIELDS-1.
  - words_written increments on the edge that leaves WRITE.
- Latency: last field accepted at edge N; wren high from N to N+1; MemoryUnit captures at edge N+1. Next field is accepted no earlier than edge N+2.
- Sustained throughput: one word per NUM_FIELDS+1 cycles.
- din holds its last committed value between writes. It changes only on a commit edge or on reset.
- Boundary conditions:
  - in_last with in_valid on field NUM_FIELDS-1: normal full word, short_pkt=0.
  - in_last on the first field: single-field word, remaining bits 0, short_pkt=1.
  - in_last without in_valid: ignored.
  - flush and in_valid in the same cycle: flush wins, the field is not accepted.
  - flush in IDLE: no effect.
  - flush during WRITE: ignored; the write completes normally.
  - in_valid held during WRITE: the field stalls, is not lost, and is accepted the following cycle.
  - words_written wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset, then send fields 0x00, 0x7F, 0x00, 0x7F, 0x00 back-to-back. Required: din = 35'b0000000_1111111_0000000_1111111_0000000, one wren pulse one cycle after the fifth accept, words_written=1, short_pkt=0.
- Send 0x7F, then 0x7F with in_last=1. Required: din = 35'b1111111_1111111_0000000_0000000_0000000, wren pulse, short_pkt=1.
- Send 3 fields, then assert flush with in_valid=1. Required: no wren, din unchanged, in_ready=0 during flush. A following 5-field word packs starting at bits [34:28].
- Hold in_valid=1 continuously with an incrementing field value. Required: in_ready low only in WRITE cycles, a wren every 6 cycles, no field dropped or duplicated.
- Assert arst while wren=1 and after 2 fields are held. Required: wren, din and words_written are 0 asynchronously; the next word packs from field 0.
- Commit 256 words. Required: words_written wraps to 0.
